// File: rtl/itlb_miss_refill.sv
// Instruction-side TLB miss handler: stalls fetch, fetches the translation from
// the unified TLB, refills a round-robin shadow ITLB slot, or reports a fault.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no miss outstanding; forwards hit-stage exceptions
// S_REQ   | request presented to the unified TLB, waiting for ready
// S_WAIT  | request accepted, waiting for the response (timeout running)
// S_FILL  | single-cycle shadow ITLB write at the victim slot
// S_RETRY | single-cycle replay pulse for the stalled fetch
// S_FAULT | single-cycle exception strobe (ITLB error or machine check)
module itlb_miss_refill #(
    parameter int ENTRIES = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss_in,
    input  logic [4:0]       exc_in,
    input  logic [31:0]      miss_ea,
    input  logic [7:0]       miss_pid,
    input  logic             miss_as,
    output logic             utlb_req_valid,
    input  logic             utlb_req_ready,
    output logic [19:0]      utlb_req_epn,
    output logic [7:0]       utlb_req_pid,
    output logic             utlb_req_as,
    input  logic             utlb_rsp_valid,
    input  logic             utlb_rsp_hit,
    input  logic [19:0]      utlb_rsp_rpn,
    input  logic [5:0]       utlb_rsp_permis,
    output logic             fill_valid,
    output logic [IDX_W-1:0] fill_idx,
    output logic [19:0]      fill_epn,
    output logic [19:0]      fill_rpn,
    output logic [7:0]       fill_tid,
    output logic             fill_ts,
    output logic [5:0]       fill_permis,
    output logic             stall,
    output logic             retry,
    output logic             exc_valid,
    output logic [4:0]       exc_code
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_FILL  = 3'd3,
        S_RETRY = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [4:0]       EXC_ITLB     = 5'd14;
    localparam logic [4:0]       EXC_MCHK     = 5'd1;
    localparam logic [7:0]       WAIT_LAST    = 8'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] VICTIM_LAST  = IDX_W'(ENTRIES - 1);

    state_t state;
    state_t state_nxt;

    logic [7:0]       wait_cnt;
    logic [IDX_W-1:0] victim;
    logic [19:0]      cap_epn;
    logic [7:0]       cap_pid;
    logic             cap_as;
    logic [19:0]      rsp_rpn_q;
    logic [5:0]       rsp_permis_q;

    logic             exc_valid_nxt;
    logic [4:0]       exc_code_nxt;

    // Page offset is irrelevant to the translation request.
    logic             unused_ea_offset;
    assign unused_ea_offset = ^miss_ea[11:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        exc_valid_nxt = 1'b0;
        exc_code_nxt  = 5'd0;
        case (state)
            S_IDLE: begin
                if (miss_in) begin
                    state_nxt = S_REQ;
                end else if (exc_in != 5'd0) begin
                    exc_valid_nxt = 1'b1;
                    exc_code_nxt  = exc_in;
                end
            end
            S_REQ: begin
                if (utlb_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response in the final counted cycle takes precedence over the timeout.
                if (utlb_rsp_valid) begin
                    if (utlb_rsp_hit) begin
                        state_nxt = S_FILL;
                    end else begin
                        state_nxt     = S_FAULT;
                        exc_valid_nxt = 1'b1;
                        exc_code_nxt  = EXC_ITLB;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt     = S_FAULT;
                    exc_valid_nxt = 1'b1;
                    exc_code_nxt  = EXC_MCHK;
                end
            end
            S_FILL:  state_nxt = S_RETRY;
            S_RETRY: state_nxt = S_IDLE;
            S_FAULT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            utlb_req_valid <= 1'b0;
            fill_valid     <= 1'b0;
            stall          <= 1'b0;
            retry          <= 1'b0;
            exc_valid      <= 1'b0;
            exc_code       <= 5'd0;
            wait_cnt       <= 8'd0;
            victim         <= '0;
            cap_epn        <= 20'd0;
            cap_pid        <= 8'd0;
            cap_as         <= 1'b0;
            rsp_rpn_q      <= 20'd0;
            rsp_permis_q   <= 6'd0;
        end else begin
            utlb_req_valid <= (state_nxt == S_REQ);
            fill_valid     <= (state_nxt == S_FILL);
            stall          <= (state_nxt == S_REQ) || (state_nxt == S_WAIT) ||
                              (state_nxt == S_FILL);
            retry          <= (state_nxt == S_RETRY);
            exc_valid      <= exc_valid_nxt;
            exc_code       <= exc_code_nxt;

            if (state == S_IDLE && miss_in) begin
                cap_epn <= miss_ea[31:12];
                cap_pid <= miss_pid;
                cap_as  <= miss_as;
            end

            if (state == S_REQ && utlb_req_ready) begin
                wait_cnt <= 8'd0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (state == S_WAIT && utlb_rsp_valid && utlb_rsp_hit) begin
                rsp_rpn_q    <= utlb_rsp_rpn;
                rsp_permis_q <= utlb_rsp_permis;
            end

            if (state == S_FILL) begin
                victim <= (victim == VICTIM_LAST) ? '0 : victim + IDX_W'(1);
            end
        end
    end

    assign utlb_req_epn = cap_epn;
    assign utlb_req_pid = cap_pid;
    assign utlb_req_as  = cap_as;
    assign fill_idx     = victim;
    assign fill_epn     = cap_epn;
    assign fill_rpn     = rsp_rpn_q;
    assign fill_tid     = cap_pid;
    assign fill_ts      = cap_as;
    assign fill_permis  = rsp_permis_q;

endmodule
